// File: rtl/flash_boot_loader_pkg.sv
// Shared types and constants for the flash-to-SDRAM boot copy engine.
package flash_boot_loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD_REQ,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_ADDR,
    WR_DATA,
    WR_END,
    FINISH,
    ERROR
  } loaderState_e;

  localparam int unsigned MAX_BURST_DEFAULT = 16;
  localparam logic [3:0]  BYTE_ENABLE_ALL   = 4'hF;

  // Words in the next burst: whatever is left, capped at the buffer depth.
  function automatic logic [8:0] burstWords(input logic [23:0] remaining,
                                            input int unsigned maxBurst);
    if (remaining > 24'(maxBurst)) begin
      return 9'(maxBurst);
    end
    return remaining[8:0];
  endfunction

endpackage

// File: rtl/loader_burst_buffer.sv
// One-burst staging FIFO between the flash read and the SDRAM write phases.
// First-word fall-through: popData always shows the oldest stored word.
module loader_burst_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned COUNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic               push,
  input  logic [WIDTH-1:0]   pushData,
  input  logic               pop,
  input  logic               flush,
  output logic [WIDTH-1:0]   popData,
  output logic [COUNT_W-1:0] count
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] rdPtr;
  logic              doPush;
  logic              doPop;

  assign doPush  = push && (count != COUNT_W'(DEPTH));
  assign doPop   = pop && (count != '0);
  assign popData = mem[rdPtr];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop)      count <= count + 1'b1;
      else if (doPop && !doPush) count <= count - 1'b1;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clock) begin
    if (doPush && !flush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/flash_boot_loader.sv
// Bus-master copy engine: burst-reads a boot image from flash and burst-writes it to SDRAM.
// Define FLASH_BOOT_LOADER_CHECKSUM_EN to add a running sum of all written words.
module flash_boot_loader
  import flash_boot_loader_pkg::*;
#(
  parameter logic [31:0] SRC_BASE  = 32'h0400_0000,
  parameter logic [31:0] DST_BASE  = 32'h0000_0000,
  parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        start,
  input  logic [23:0] lengthWords,
  output logic        busRequest,
  input  logic        busGrant,
  output logic        beginTransactionOut,
  output logic        endTransactionOut,
  output logic        readNotWriteOut,
  output logic        dataValidOut,
  output logic [31:0] addressDataOut,
  output logic [3:0]  byteEnablesOut,
  output logic [7:0]  burstSizeOut,
  input  logic [31:0] addressDataIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  input  logic        busyIn,
  input  logic        busErrorIn,
  output logic        loaderBusy,
  output logic        loaderDone,
  output logic        loaderError
`ifdef FLASH_BOOT_LOADER_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  localparam int unsigned COUNT_W = $clog2(MAX_BURST + 1);

  loaderState_e       state;
  loaderState_e       nextState;
  logic [23:0]        remaining;
  logic [23:0]        offset;
  logic [8:0]         burstN;
  logic [8:0]         rdCount;
  logic [9:0]         rdAfter;
  logic [31:0]        offsetBytes;
  logic               startAccept;
  logic               rdOverrun;
  logic               rdShort;
  logic               lastWrite;
  logic               bufPush;
  logic               bufPop;
  logic               bufFlush;
  logic [31:0]        bufData;
  logic [COUNT_W-1:0] bufCount;

  assign burstN      = burstWords(remaining, MAX_BURST);
  assign offsetBytes = {6'b0, offset, 2'b00};
  assign startAccept = (state == IDLE) && start;
  assign rdAfter     = {1'b0, rdCount} + 10'(dataValidIn);
  assign rdOverrun   = dataValidIn && (rdCount >= burstN);
  assign rdShort     = endTransactionIn && (rdAfter < {1'b0, burstN});
  assign lastWrite   = (bufCount == COUNT_W'(1)) && !busyIn;

  assign bufPush  = (state == RD_DATA) && dataValidIn && (rdCount < burstN) && !busErrorIn;
  assign bufPop   = (state == WR_DATA) && !busyIn;
  assign bufFlush = (state == ERROR);

  loader_burst_buffer #(
    .DEPTH(MAX_BURST),
    .WIDTH(32)
  ) burstBuffer (
    .clock   (clock),
    .resetN  (resetN),
    .push    (bufPush),
    .pushData(addressDataIn),
    .pop     (bufPop),
    .flush   (bufFlush),
    .popData (bufData),
    .count   (bufCount)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= nextState;
  end

  // A bus error anywhere in a copy overrides the normal flow, even a same-cycle end.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (start) nextState = (lengthWords == '0) ? FINISH : RD_REQ;
      RD_REQ:  if (busGrant) nextState = RD_ADDR;
      RD_ADDR: nextState = RD_DATA;
      RD_DATA: begin
        if (rdOverrun || rdShort) nextState = ERROR;
        else if (endTransactionIn) nextState = WR_REQ;
      end
      WR_REQ:  if (busGrant) nextState = WR_ADDR;
      WR_ADDR: nextState = WR_DATA;
      WR_DATA: if (lastWrite) nextState = WR_END;
      WR_END:  nextState = (remaining == 24'(burstN)) ? FINISH : RD_REQ;
      FINISH:  nextState = IDLE;
      ERROR:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (busErrorIn && (state != IDLE) && (state != ERROR)) nextState = ERROR;
  end

  always_comb begin
    busRequest          = 1'b0;
    beginTransactionOut = 1'b0;
    endTransactionOut   = 1'b0;
    readNotWriteOut     = 1'b0;
    dataValidOut        = 1'b0;
    addressDataOut      = '0;
    byteEnablesOut      = '0;
    burstSizeOut        = '0;
    loaderBusy          = (state != IDLE);
    unique case (state)
      RD_REQ, WR_REQ: busRequest = 1'b1;
      RD_ADDR: begin
        busRequest          = 1'b1;
        beginTransactionOut = 1'b1;
        readNotWriteOut     = 1'b1;
        addressDataOut      = SRC_BASE + offsetBytes;
        byteEnablesOut      = BYTE_ENABLE_ALL;
        burstSizeOut        = 8'(burstN - 9'd1);
      end
      RD_DATA: begin
        busRequest      = 1'b1;
        readNotWriteOut = 1'b1;
        byteEnablesOut  = BYTE_ENABLE_ALL;
        burstSizeOut    = 8'(burstN - 9'd1);
      end
      WR_ADDR: begin
        busRequest          = 1'b1;
        beginTransactionOut = 1'b1;
        addressDataOut      = DST_BASE + offsetBytes;
        byteEnablesOut      = BYTE_ENABLE_ALL;
        burstSizeOut        = 8'(burstN - 9'd1);
      end
      WR_DATA: begin
        busRequest     = 1'b1;
        dataValidOut   = 1'b1;
        addressDataOut = bufData;
        byteEnablesOut = BYTE_ENABLE_ALL;
        burstSizeOut   = 8'(burstN - 9'd1);
      end
      WR_END: begin
        busRequest        = 1'b1;
        endTransactionOut = 1'b1;
        byteEnablesOut    = BYTE_ENABLE_ALL;
        burstSizeOut      = 8'(burstN - 9'd1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      remaining   <= '0;
      offset      <= '0;
      rdCount     <= '0;
      loaderDone  <= 1'b0;
      loaderError <= 1'b0;
    end else begin
      if (startAccept) begin
        remaining   <= lengthWords;
        offset      <= '0;
        loaderDone  <= 1'b0;
        loaderError <= 1'b0;
      end
      if (state == RD_ADDR) rdCount <= '0;
      else if (bufPush)     rdCount <= rdCount + 9'd1;
      if (state == WR_END) begin
        offset    <= offset + 24'(burstN);
        remaining <= remaining - 24'(burstN);
      end
      if (state == FINISH) loaderDone  <= 1'b1;
      if (state == ERROR)  loaderError <= 1'b1;
    end
  end

`ifdef FLASH_BOOT_LOADER_CHECKSUM_EN
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)          checksum <= '0;
    else if (startAccept) checksum <= '0;
    else if (bufPop)      checksum <= checksum + bufData;
  end
`endif

endmodule

// File: tb/tb_flash_boot_loader.sv
// Scoreboard bench for flash_boot_loader: flash/SDRAM slave models plus a decoupled monitor.
module tb_flash_boot_loader;

  localparam logic [31:0] SRC = 32'h0400_0000;
  localparam logic [31:0] DST = 32'h0000_0000;
  localparam int          MB  = 16;

  logic        clock = 1'b0;
  logic        resetN;
  logic        start;
  logic [23:0] lengthWords;
  logic        busRequest;
  logic        busGrant;
  logic        beginTransactionOut;
  logic        endTransactionOut;
  logic        readNotWriteOut;
  logic        dataValidOut;
  logic [31:0] addressDataOut;
  logic [3:0]  byteEnablesOut;
  logic [7:0]  burstSizeOut;
  logic [31:0] addressDataIn;
  logic        dataValidIn;
  logic        endTransactionIn;
  logic        busyIn;
  logic        busErrorIn;
  logic        loaderBusy;
  logic        loaderDone;
  logic        loaderError;
`ifdef FLASH_BOOT_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  flash_boot_loader #(
    .SRC_BASE (SRC),
    .DST_BASE (DST),
    .MAX_BURST(MB)
  ) dut (
    .clock              (clock),
    .resetN             (resetN),
    .start              (start),
    .lengthWords        (lengthWords),
    .busRequest         (busRequest),
    .busGrant           (busGrant),
    .beginTransactionOut(beginTransactionOut),
    .endTransactionOut  (endTransactionOut),
    .readNotWriteOut    (readNotWriteOut),
    .dataValidOut       (dataValidOut),
    .addressDataOut     (addressDataOut),
    .byteEnablesOut     (byteEnablesOut),
    .burstSizeOut       (burstSizeOut),
    .addressDataIn      (addressDataIn),
    .dataValidIn        (dataValidIn),
    .endTransactionIn   (endTransactionIn),
    .busyIn             (busyIn),
    .busErrorIn         (busErrorIn),
    .loaderBusy         (loaderBusy),
    .loaderDone         (loaderDone),
    .loaderError        (loaderError)
`ifdef FLASH_BOOT_LOADER_CHECKSUM_EN
    ,
    .checksum           (checksum)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  size;
  } rdExp_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  size;
    int          cycles;
  } wrExp_t;

  rdExp_t      expRd[$];
  wrExp_t      expWr[$];
  logic [31:0] expData[$];
  logic [31:0] expSum;

  logic [31:0] flash [64];
  logic [31:0] sdram [64];

  int checks = 0;
  int errors = 0;

  int          errBurst = -1;
  int          errWord = 0;
  int          stallWord = 99;
  int          stallLeft = 0;
  bit          gapsEn = 1'b0;
  int          rdBurstNum = -1;
  int          wrIdx = 0;
  bit          busReqSeen = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic failEvent(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: actual=unexpected bus event required=none at %0t", name, $time);
  endtask

  // Arbiter: grants after a random delay and holds the grant while requested.
  initial begin
    busGrant = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (!busRequest)   busGrant = 1'b0;
      else if (!busGrant) busGrant = 1'($urandom_range(0, 1));
    end
  end

  // Flash slave: streams the requested burst, optionally with gaps or an injected bus error.
  initial begin
    bit          rdActive = 1'b0;
    int          rdIdx = 0;
    int          rdN = 0;
    logic [31:0] rdAddr = '0;
    dataValidIn      = 1'b0;
    endTransactionIn = 1'b0;
    busErrorIn       = 1'b0;
    addressDataIn    = '0;
    forever begin
      @(posedge clock);
      #1;
      dataValidIn      = 1'b0;
      endTransactionIn = 1'b0;
      busErrorIn       = 1'b0;
      addressDataIn    = '0;
      if (!resetN) begin
        rdActive = 1'b0;
      end else begin
        if (rdActive && (!gapsEn || ($urandom_range(0, 3) != 0))) begin
          addressDataIn = flash[(((rdAddr - SRC) >> 2) + rdIdx) & 63];
          dataValidIn   = 1'b1;
          if ((rdBurstNum == errBurst) && (rdIdx == errWord)) begin
            busErrorIn = 1'b1;
            rdActive   = 1'b0;
          end else if (rdIdx == rdN - 1) begin
            endTransactionIn = 1'b1;
            rdActive         = 1'b0;
          end
          rdIdx++;
        end
        if (beginTransactionOut && readNotWriteOut) begin
          rdActive = 1'b1;
          rdIdx    = 0;
          rdN      = int'(burstSizeOut) + 1;
          rdAddr   = addressDataOut;
          rdBurstNum++;
        end
      end
    end
  end

  // SDRAM slave: stalls the chosen word of the first write burst for stallLeft cycles.
  initial begin
    busyIn = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (resetN && dataValidOut && (wrIdx == stallWord) && (stallLeft > 0)) begin
        busyIn = 1'b1;
        stallLeft--;
      end else begin
        busyIn = 1'b0;
      end
    end
  end

  // Monitor: pops expectations as the DUT presents transactions and accepted words.
  initial begin
    bit          inWrite = 1'b0;
    bit          errSeen = 1'b0;
    int          wrCycles = 0;
    int          curExpCycles = 0;
    logic [31:0] curWrAddr = '0;
    rdExp_t      r;
    wrExp_t      w;
    forever begin
      @(negedge clock);
      if (!resetN) begin
        inWrite = 1'b0;
        errSeen = 1'b0;
        wrIdx   = 0;
      end else begin
        if (busRequest) busReqSeen = 1'b1;
        if (errSeen) begin
          checkOutput("busReqDropAfterError", 32'(busRequest), 32'd0);
          errSeen = 1'b0;
        end
        if (busErrorIn && loaderBusy) errSeen = 1'b1;
        if (beginTransactionOut && readNotWriteOut) begin
          if (expRd.size() == 0) failEvent("unexpectedRead");
          else begin
            r = expRd.pop_front();
            checkOutput("rdAddr", addressDataOut, r.addr);
            checkOutput("rdBurstSize", 32'(burstSizeOut), 32'(r.size));
            checkOutput("rdByteEn", 32'(byteEnablesOut), 32'hF);
          end
        end
        if (beginTransactionOut && !readNotWriteOut) begin
          if (expWr.size() == 0) failEvent("unexpectedWrite");
          else begin
            w = expWr.pop_front();
            checkOutput("wrAddr", addressDataOut, w.addr);
            checkOutput("wrBurstSize", 32'(burstSizeOut), 32'(w.size));
            curExpCycles = w.cycles;
          end
          inWrite   = 1'b1;
          wrCycles  = 1;
          wrIdx     = 0;
          curWrAddr = addressDataOut;
        end else if (inWrite) begin
          wrCycles++;
        end
        if (dataValidOut) begin
          if (expData.size() == 0) failEvent("unexpectedWord");
          else if (busyIn) checkOutput("heldWord", addressDataOut, expData[0]);
          else begin
            checkOutput("wrData", addressDataOut, expData.pop_front());
            sdram[(((curWrAddr - DST) >> 2) + wrIdx) & 63] = addressDataOut;
            wrIdx++;
          end
        end
        if (endTransactionOut) begin
          if (inWrite) checkOutput("wrBurstCycles", 32'(wrCycles), 32'(curExpCycles));
          else failEvent("strayWriteEnd");
          inWrite = 1'b0;
        end
      end
    end
  end

  task automatic fillImage(input bit ramp);
    for (int i = 0; i < 64; i++) flash[i] = ramp ? 32'(i + 1) : $urandom();
  endtask

  task automatic pulseStart(input int len);
    start       = 1'b1;
    lengthWords = 24'(len);
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Reference model: splits the copy into capped bursts and queues what the bus should show.
  task automatic applyStimulus(input int len, input int sWord, input int sCycles,
                               input int eBurst, input int eWord, input bit gaps);
    int rem = len;
    int off = 0;
    int b = 0;
    int n;
    for (int i = 0; i < 64; i++) sdram[i] = 32'hDEAD_BEEF;
    stallWord  = sWord;
    stallLeft  = sCycles;
    errBurst   = eBurst;
    errWord    = eWord;
    gapsEn     = gaps;
    rdBurstNum = -1;
    busReqSeen = 1'b0;
    expSum     = '0;
    while (rem > 0) begin
      n = (rem < MB) ? rem : MB;
      expRd.push_back('{SRC + 32'(off) * 4, 8'(n - 1)});
      if (b == eBurst) break;
      expWr.push_back('{DST + 32'(off) * 4, 8'(n - 1),
                        n + 2 + (((b == 0) && (sWord < n)) ? sCycles : 0)});
      for (int i = 0; i < n; i++) begin
        expData.push_back(flash[off + i]);
        expSum += flash[off + i];
      end
      off += n;
      rem -= n;
      b++;
    end
    @(posedge clock);
    #1;
    pulseStart(len);
    checkOutput("busyAfterStart", 32'(loaderBusy), 32'd1);
    checkOutput("busReqAfterStart", 32'(busRequest), 32'(len != 0));
  endtask

  task automatic waitIdle(input int limit);
    bit ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (loaderDone || loaderError) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) failEvent("timeoutWaitingForDone");
  endtask

  task automatic checkRun(input int nCopied, input bit expDone);
    checkOutput("loaderDone", 32'(loaderDone), 32'(expDone));
    checkOutput("loaderError", 32'(loaderError), 32'(!expDone));
    checkOutput("loaderBusyEnd", 32'(loaderBusy), 32'd0);
    checkOutput("rdQueueDrained", 32'(expRd.size()), 32'd0);
    checkOutput("wrQueueDrained", 32'(expWr.size()), 32'd0);
    checkOutput("dataQueueDrained", 32'(expData.size()), 32'd0);
    for (int i = 0; i < nCopied; i++) checkOutput("sdramWord", sdram[i], flash[i]);
    if (nCopied < 64) checkOutput("sdramUntouched", sdram[nCopied], 32'hDEAD_BEEF);
    expRd.delete();
    expWr.delete();
    expData.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL globalWatchdog: actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit sawData;
    int len;
    resetN      = 1'b0;
    start       = 1'b0;
    lengthWords = '0;
    repeat (3) @(negedge clock);
    checkOutput("rstBusRequest", 32'(busRequest), 32'd0);
    checkOutput("rstBegin", 32'(beginTransactionOut), 32'd0);
    checkOutput("rstEnd", 32'(endTransactionOut), 32'd0);
    checkOutput("rstDataValid", 32'(dataValidOut), 32'd0);
    checkOutput("rstAddrData", addressDataOut, 32'd0);
    checkOutput("rstByteEn", 32'(byteEnablesOut), 32'd0);
    checkOutput("rstBurstSize", 32'(burstSizeOut), 32'd0);
    checkOutput("rstBusy", 32'(loaderBusy), 32'd0);
    checkOutput("rstDone", 32'(loaderDone), 32'd0);
    checkOutput("rstError", 32'(loaderError), 32'd0);
    @(posedge clock);
    #2 resetN = 1'b1;

    $display("[TB] 40-word copy, no stalls, with an ignored start mid-run");
    fillImage(1'b0);
    applyStimulus(40, 99, 0, -1, 0, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    pulseStart(7);
    waitIdle(2000);
    checkRun(40, 1'b1);
`ifdef FLASH_BOOT_LOADER_CHECKSUM_EN
    checkOutput("checksum40", checksum, expSum);
`endif

    $display("[TB] zero-length copy");
    applyStimulus(0, 99, 0, -1, 0, 1'b0);
    waitIdle(2);
    checkRun(0, 1'b1);
    checkOutput("zeroLenNoRequest", 32'(busReqSeen), 32'd0);

    $display("[TB] 16-word copy with word 3 stalled for 5 cycles");
    fillImage(1'b0);
    applyStimulus(16, 3, 5, -1, 0, 1'b0);
    waitIdle(2000);
    checkRun(16, 1'b1);

    $display("[TB] bus error on read word 7 of burst 2");
    fillImage(1'b0);
    applyStimulus(40, 99, 0, 1, 7, 1'b1);
    waitIdle(2000);
    checkRun(16, 1'b0);

    $display("[TB] reset during a write burst, then a 4-word copy");
    fillImage(1'b0);
    applyStimulus(20, 99, 0, -1, 0, 1'b0);
    sawData = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (dataValidOut) begin
        sawData = 1'b1;
        break;
      end
    end
    if (!sawData) failEvent("timeoutWaitingForWrite");
    #2 resetN = 1'b0;
    #1;
    checkOutput("asyncRstBusRequest", 32'(busRequest), 32'd0);
    checkOutput("asyncRstDataValid", 32'(dataValidOut), 32'd0);
    checkOutput("asyncRstEnd", 32'(endTransactionOut), 32'd0);
    checkOutput("asyncRstByteEn", 32'(byteEnablesOut), 32'd0);
    checkOutput("asyncRstBusy", 32'(loaderBusy), 32'd0);
    expRd.delete();
    expWr.delete();
    expData.delete();
    stallLeft = 0;
    repeat (2) @(negedge clock);
    @(posedge clock);
    #2 resetN = 1'b1;
    fillImage(1'b0);
    applyStimulus(4, 99, 0, -1, 0, 1'b0);
    waitIdle(500);
    checkRun(4, 1'b1);

    $display("[TB] randomized copies with gaps and stalls");
    for (int r = 0; r < 4; r++) begin
      fillImage(1'b0);
      len = $urandom_range(1, 50);
      applyStimulus(len, $urandom_range(0, MB - 1), $urandom_range(0, 4), -1, 0, 1'b1);
      waitIdle(3000);
      checkRun(len, 1'b1);
    end

`ifdef FLASH_BOOT_LOADER_CHECKSUM_EN
    $display("[TB] checksum of ramp image 1..16");
    fillImage(1'b1);
    applyStimulus(16, 99, 0, -1, 0, 1'b0);
    waitIdle(2000);
    checkRun(16, 1'b1);
    checkOutput("checksumRamp", checksum, 32'd136);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flash_boot_loader.md
# flash_boot_loader

Bus-master copy engine that moves a boot image from SPI flash (base 0x04000000) into SDRAM (base 0x00000000) over the shared multiplexed address/data bus. It sits directly upstream of the SDRAM controller and downstream of the flash controller: it issues burst reads to flash, buffers one burst locally, then writes it to SDRAM as a burst. It runs once after `start`, while the CPU is held off the bus by the arbiter.

## Interface
Parameters:
- SRC_BASE, 32'h04000000, flash byte address of word 0 of the image.
- DST_BASE, 32'h00000000, SDRAM byte address of word 0.
- MAX_BURST, 16, words per burst. Power of two, at most 256. Also the buffer depth.

Ports:
- clock  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse. Ignored unless idle.
- lengthWords  in  24  number of 32-bit words to copy. Sampled on `start`.
- busRequest  out  1  bus request to the arbiter.
- busGrant  in  1  arbiter grant.
- beginTransactionOut  out  1  one-cycle transaction start.
- endTransactionOut  out  1  one-cycle end of a write burst.
- readNotWriteOut  out  1  transaction direction (1 = read).
- dataValidOut  out  1  write word valid.
- addressDataOut  out  32  address, or write data.
- byteEnablesOut  out  4  always 4'hF during a transaction, else 0.
- burstSizeOut  out  8  burst word count minus 1.
- addressDataIn  in  32  read data.
- dataValidIn  in  1  read word valid.
- endTransactionIn  in  1  slave ends a read burst.
- busyIn  in  1  slave stall.
- busErrorIn  in  1  bus error.
- loaderBusy  out  1  high from `start` until done or error.
- loaderDone  out  1  sticky. Cleared by the next accepted `start`.
- loaderError  out  1  sticky. Cleared by the next accepted `start`.

## Operation
- States: IDLE, RD_REQ, RD_ADDR, RD_DATA, WR_REQ, WR_ADDR, WR_DATA, WR_END, FINISH, ERROR.
- IDLE + `start`:
  - `lengthWords` == 0 → FINISH.
  - Otherwise → RD_REQ. Latch `remaining` = `lengthWords` and `offset` = 0.
- Burst length: `n` = min(`remaining`, MAX_BURST). `burstSizeOut` = n-1.
- RD_REQ: assert `busRequest`. On `busGrant` → RD_ADDR.
- RD_ADDR (one cycle):
  - `beginTransactionOut` = 1, `readNotWriteOut` = 1.
  - `addressDataOut` = SRC_BASE + 4·offset.
  - → RD_DATA.
- RD_DATA: each `dataValidIn` pushes `addressDataIn` into the buffer. On `endTransactionIn` → WR_REQ.
  - If `endTransactionIn` arrives with fewer than `n` words received → ERROR.
- WR_REQ → WR_ADDR on `busGrant`. `busRequest` stays high from RD_REQ until WR_END.
- WR_ADDR (one cycle): `beginTransactionOut` = 1, `readNotWriteOut` = 0, address = DST_BASE + 4·offset.
- WR_DATA: drive buffered words with `dataValidOut` = 1.
  - Advance to the next word only on cycles where `busyIn` = 0.
  - While `busyIn` = 1, hold the current word stable.
  - After the last word is accepted → WR_END.
- WR_END (one cycle): `endTransactionOut` = 1.
  - `offset` += n, `remaining` -= n.
  - `remaining` == 0 → FINISH, else → RD_REQ.
- FINISH: set `loaderDone`, clear `loaderBusy`, → IDLE.
- `busErrorIn` in any non-IDLE state → ERROR.
  - ERROR: set `loaderError`, drop `busRequest`, flush the buffer, → IDLE.
- Offset arithmetic is 24-bit words, shifted left by 2 and added to the 32-bit base. Address wrap modulo 2^32 is allowed.

## Timing
- Reset values:
  - All outputs 0, `byteEnablesOut` = 0.
  - State IDLE, buffer empty, `remaining` = 0, `offset` = 0.
- `busRequest` rises the cycle after `start`.
- `beginTransactionOut` is asserted the cycle after `busGrant` is first seen high.
- First write word appears the cycle after WR_ADDR.
- With `busyIn` = 0, a write burst takes n+2 cycles (WR_ADDR + n data + WR_END).
- Buffer full cannot occur: reads never exceed `n`. A `dataValidIn` beyond `n` words → ERROR.
- `busErrorIn` together with `endTransactionIn` in the same cycle: error wins.
- `resetN` low mid-burst: all outputs drop asynchronously, with no `endTransactionOut`.
- `start` while `loaderBusy` = 1 is ignored.

## Configuration
- FLASH_BOOT_LOADER_CHECKSUM_EN defined:
  - Adds output `checksum` [31:0]: the modulo-2^32 sum of every word written to SDRAM.
  - Cleared on accepted `start`, final value valid when `loaderDone` rises.
- Undefined: no `checksum` port and no adder.

## Structure
- Package `flash_boot_loader_pkg`: the state enum, the MAX_BURST default, and the byte-enable constant 4'hF.
- One sub-module, `loader_burst_buffer`:
  - MAX_BURST×32 synchronous FIFO.
  - Ports: push, pop, flush, count.
  - Read data available the cycle after pop, or first-word fall-through.

## Test plan
- `lengthWords` = 40, MAX_BURST = 16, no stalls → three read/write burst pairs:
  - Bursts of 16, 16 and 8 words (`burstSizeOut` = 15, 15, 7).
  - Write addresses 0x0, 0x40, 0x80.
  - SDRAM model matches flash; `loaderDone` = 1.
- `lengthWords` = 0 → no bus request; `loaderDone` = 1 within 2 cycles.
- `busyIn` held high for 5 cycles on write word 3 → word 3 held stable; the 16-word burst completes in 23 cycles.
- `busErrorIn` on read word 7 of burst 2 → `loaderError` = 1, `busRequest` = 0 next cycle, no write of burst 2.
- `resetN` asserted mid-WR_DATA, then `start` with `lengthWords` = 4 → clean single 4-word copy.
- Checksum build: image of words 1..16 → `checksum` = 136 at `loaderDone`.
